// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result source, buffered entry layout.
package wb_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_e;

  typedef struct packed {
    wb_src_e               src;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/write_back_unit_if.sv
// Result inputs, register-file write port and forwarding lookup of the write-back stage.
interface write_back_unit_if;
  import wb_pkg::*;
  logic                  alu_valid, alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  mem_valid, mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] RW;
  logic [DATA_W-1:0]     BusW1, BusW2;
  logic                  sig_enable_write1, sig_enable_write2;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic                  fwd_hit;
  logic [DATA_W-1:0]     fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_addr,
    input  alu_ready, mem_ready, RW, BusW1, BusW2,
           sig_enable_write1, sig_enable_write2, fwd_hit, fwd_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_addr,
    output alu_ready, mem_ready, RW, BusW1, BusW2,
           sig_enable_write1, sig_enable_write2, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_pending_fifo.sv
// Pending-write FIFO: two ordered pushes and one pop per cycle, entries exposed head-first.
module wb_pending_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        push0,
  input  wb_entry_t                   din0,
  input  logic                        push1,
  input  wb_entry_t                   din1,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic [CNT_W-1:0]            count,
  output wb_entry_t [DEPTH-1:0]       ent,
  output logic [DEPTH-1:0]            ent_vld
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] wrap(input int p);
    return PTR_W'(p % DEPTH);
  endfunction

  always_comb begin
    mem_d = mem_q;
    // push1 is always the younger entry, landing behind push0 when both fire
    if (push0) mem_d[wr_q] = din0;
    if (push1) mem_d[wrap(int'(wr_q) + int'(push0))] = din1;
    wr_d  = wrap(int'(wr_q) + int'(push0) + int'(push1));
    rd_d  = pop ? wrap(int'(rd_q) + 1) : rd_q;
    cnt_d = CNT_W'(int'(cnt_q) + int'(push0) + int'(push1) - int'(pop));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i]     = mem_q[wrap(int'(rd_q) + i)];
    assign ent_vld[i] = CNT_W'(i) < cnt_q;
  end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: orders ALU/load results onto a single register-file write port.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  write_back_unit_if.slave             wb,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                  push0, push1, pop, alu_rdy, alu_acc, iss_vld;
  wb_entry_t             din0, din1, head, iss, mem_e, alu_e;
  wb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]      ent_vld;

  logic [REG_ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0]     busw1_q, busw1_d, busw2_q, busw2_d;
  logic                  en1_q, en1_d, en2_q, en2_d;

  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock, .reset_n, .push0, .din0, .push1, .din1, .pop,
    .head, .count(pending_count), .ent, .ent_vld
  );

  assign mem_e   = '{src: SRC_MEM, rd: wb.mem_rd, data: wb.mem_data};
  assign alu_e   = '{src: SRC_ALU, rd: wb.alu_rd, data: wb.alu_data};
  // full buffer can still absorb one push since the head drains this cycle
  assign alu_rdy = !(wb.mem_valid && pending_count == CNT_W'(DEPTH));
  assign alu_acc = wb.alu_valid && alu_rdy;

  always_comb begin
    push0   = 1'b0;
    push1   = 1'b0;
    din0    = mem_e;
    din1    = alu_e;
    pop     = 1'b0;
    iss_vld = 1'b0;
    iss     = mem_e;
    if (pending_count != '0) begin
      pop     = 1'b1;
      iss_vld = 1'b1;
      iss     = head;
      if (wb.mem_valid) begin
        push0 = 1'b1;
        push1 = alu_acc;
      end else begin
        push0 = alu_acc;
        din0  = alu_e;
      end
    end else if (wb.mem_valid) begin
      iss_vld = 1'b1;
      push0   = alu_acc;
      din0    = alu_e;
    end else if (alu_acc) begin
      iss_vld = 1'b1;
      iss     = alu_e;
    end
    en1_d   = iss_vld && iss.src == SRC_ALU;
    en2_d   = iss_vld && iss.src == SRC_MEM;
    rw_d    = iss_vld ? iss.rd : rw_q;
    busw1_d = en1_d ? iss.data : busw1_q;
    busw2_d = en2_d ? iss.data : busw2_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rw_q    <= '0;
      busw1_q <= '0;
      busw2_q <= '0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
    end else begin
      rw_q    <= rw_d;
      busw1_q <= busw1_d;
      busw2_q <= busw2_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
    end
  end

  // Later matches override earlier ones: issue stage is oldest, buffer tail youngest.
  always_comb begin
    wb.fwd_hit  = 1'b0;
    wb.fwd_data = '0;
    if ((en1_q || en2_q) && rw_q == wb.fwd_addr) begin
      wb.fwd_hit  = 1'b1;
      wb.fwd_data = en1_q ? busw1_q : busw2_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent[i].rd == wb.fwd_addr) begin
        wb.fwd_hit  = 1'b1;
        wb.fwd_data = ent[i].data;
      end
    end
  end

  assign wb.alu_ready         = alu_rdy;
  assign wb.mem_ready         = 1'b1;
  assign wb.RW                = rw_q;
  assign wb.BusW1             = busw1_q;
  assign wb.BusW2             = busw2_q;
  assign wb.sig_enable_write1 = en1_q;
  assign wb.sig_enable_write2 = en2_q;
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit with a register-file model on the write port.
module tb_write_back_unit;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pending_count;
  logic [15:0] rf [8];
  int          total = 0;
  int          bad = 0;

  write_back_unit_if wb_if ();

  write_back_unit #(.DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .wb(wb_if), .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 8; i++) rf[i] = '0;
  always @(posedge clock) begin
    if (wb_if.sig_enable_write1) rf[wb_if.RW] <= wb_if.BusW1;
    if (wb_if.sig_enable_write2) rf[wb_if.RW] <= wb_if.BusW2;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    wb_if.alu_valid = 0; wb_if.alu_rd = 0; wb_if.alu_data = 0;
    wb_if.mem_valid = 0; wb_if.mem_rd = 0; wb_if.mem_data = 0;
  endtask

  task automatic test_reset;
    idle_in();
    wb_if.fwd_addr = 0;
    #12;
    total += 6;
    if (wb_if.sig_enable_write1 !== 1'b0) begin bad++; $display("FAIL reset_en1 got=%0b exp=0", wb_if.sig_enable_write1); end
    if (wb_if.sig_enable_write2 !== 1'b0) begin bad++; $display("FAIL reset_en2 got=%0b exp=0", wb_if.sig_enable_write2); end
    if (pending_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
    if (wb_if.RW !== 3'd0 || wb_if.BusW1 !== 16'd0 || wb_if.BusW2 !== 16'd0) begin
      bad++; $display("FAIL reset_bus got RW=%0d W1=%0h W2=%0h exp 0/0/0", wb_if.RW, wb_if.BusW1, wb_if.BusW2);
    end
    if (wb_if.mem_ready !== 1'b1) begin bad++; $display("FAIL reset_mem_ready got=%0b exp=1", wb_if.mem_ready); end
    if (wb_if.fwd_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%0b exp=0", wb_if.fwd_hit); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_alu;
    wb_if.alu_valid = 1; wb_if.alu_rd = 1; wb_if.alu_data = 16'd8;
    tick();
    idle_in();
    total += 2;
    if (wb_if.RW !== 3'd1 || wb_if.BusW1 !== 16'd8) begin
      bad++; $display("FAIL single_bus got RW=%0d W1=%0h exp 1/8", wb_if.RW, wb_if.BusW1);
    end
    if (wb_if.sig_enable_write1 !== 1'b1 || wb_if.sig_enable_write2 !== 1'b0) begin
      bad++; $display("FAIL single_en got=%0b%0b exp=10", wb_if.sig_enable_write1, wb_if.sig_enable_write2);
    end
    tick();
    total += 2;
    if (rf[1] !== 16'd8) begin bad++; $display("FAIL single_commit got=%0h exp=8", rf[1]); end
    if (wb_if.sig_enable_write1 !== 1'b0) begin bad++; $display("FAIL single_drop got=%0b exp=0", wb_if.sig_enable_write1); end
  endtask

  task automatic test_collision;
    wb_if.mem_valid = 1; wb_if.mem_rd = 2; wb_if.mem_data = 16'd32;
    wb_if.alu_valid = 1; wb_if.alu_rd = 3; wb_if.alu_data = 16'd64;
    #1;
    total++;
    if (wb_if.alu_ready !== 1'b1) begin bad++; $display("FAIL coll_ready got=%0b exp=1", wb_if.alu_ready); end
    tick();
    idle_in();
    total++;
    if (wb_if.RW !== 3'd2 || wb_if.BusW2 !== 16'd32 || wb_if.sig_enable_write2 !== 1'b1 ||
        wb_if.sig_enable_write1 !== 1'b0 || pending_count !== 2'd1) begin
      bad++; $display("FAIL coll_mem got RW=%0d W2=%0h en=%0b%0b cnt=%0d exp 2/20/01/1", wb_if.RW, wb_if.BusW2,
                      wb_if.sig_enable_write1, wb_if.sig_enable_write2, pending_count);
    end
    tick();
    total++;
    if (wb_if.RW !== 3'd3 || wb_if.BusW1 !== 16'd64 || wb_if.sig_enable_write1 !== 1'b1 ||
        wb_if.sig_enable_write2 !== 1'b0 || pending_count !== 2'd0 || wb_if.BusW2 !== 16'd32) begin
      bad++; $display("FAIL coll_alu got RW=%0d W1=%0h W2=%0h en=%0b%0b cnt=%0d exp 3/40/20/10/0", wb_if.RW,
                      wb_if.BusW1, wb_if.BusW2, wb_if.sig_enable_write1, wb_if.sig_enable_write2, pending_count);
    end
    tick();
  endtask

  task automatic test_fill;
    logic [2:0]  m_rd [3];
    logic [15:0] m_d  [3];
    logic [2:0]  a_rd [3];
    logic [15:0] a_d  [3];
    logic [2:0]  x_rd [6];
    logic [15:0] x_d  [6];
    logic        x_mem[6];
    int          x_cnt[6];
    logic        x_rdy[6];
    m_rd = '{3'd4, 3'd6, 3'd0}; m_d = '{16'h100, 16'h101, 16'h102};
    a_rd = '{3'd5, 3'd7, 3'd1}; a_d = '{16'h200, 16'h201, 16'h202};
    x_rd  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
    x_d   = '{16'h100, 16'h200, 16'h101, 16'h201, 16'h102, 16'h0};
    x_mem = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    x_cnt = '{1, 2, 2, 1, 0, 0};
    x_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        wb_if.mem_valid = 1; wb_if.mem_rd = m_rd[i]; wb_if.mem_data = m_d[i];
        wb_if.alu_valid = 1; wb_if.alu_rd = a_rd[i]; wb_if.alu_data = a_d[i];
      end else idle_in();
      #1;
      total++;
      if (wb_if.alu_ready !== x_rdy[i]) begin bad++; $display("FAIL fill_ready[%0d] got=%0b exp=%0b", i, wb_if.alu_ready, x_rdy[i]); end
      tick();
      total++;
      if (pending_count !== 2'(x_cnt[i])) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, pending_count, x_cnt[i]); end
      total++;
      if (i == 5) begin
        if (wb_if.sig_enable_write1 !== 1'b0 || wb_if.sig_enable_write2 !== 1'b0) begin
          bad++; $display("FAIL fill_extra got en=%0b%0b exp=00", wb_if.sig_enable_write1, wb_if.sig_enable_write2);
        end
      end else if (wb_if.sig_enable_write2 !== x_mem[i] || wb_if.sig_enable_write1 !== !x_mem[i] ||
                   wb_if.RW !== x_rd[i] || (x_mem[i] ? wb_if.BusW2 : wb_if.BusW1) !== x_d[i]) begin
        bad++; $display("FAIL fill_issue[%0d] got RW=%0d W1=%0h W2=%0h en=%0b%0b exp RW=%0d data=%0h mem=%0b", i, wb_if.RW,
                        wb_if.BusW1, wb_if.BusW2, wb_if.sig_enable_write1, wb_if.sig_enable_write2, x_rd[i], x_d[i], x_mem[i]);
      end
    end
    total++;
    if (rf[1] !== 16'd8 || rf[4] !== 16'h100 || rf[5] !== 16'h200 || rf[6] !== 16'h101 || rf[7] !== 16'h201 || rf[0] !== 16'h102) begin
      bad++; $display("FAIL fill_rf got r0=%0h r1=%0h r4=%0h r5=%0h r6=%0h r7=%0h exp 102/8/100/200/101/201",
                      rf[0], rf[1], rf[4], rf[5], rf[6], rf[7]);
    end
  endtask

  task automatic test_forward;
    wb_if.mem_valid = 1; wb_if.mem_rd = 2; wb_if.mem_data = 16'd32;
    wb_if.alu_valid = 1; wb_if.alu_rd = 2; wb_if.alu_data = 16'd64;
    wb_if.fwd_addr = 2;
    #1;
    total++;
    if (wb_if.fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_arrival got=%0b exp=0", wb_if.fwd_hit); end
    tick();
    idle_in();
    #1;
    total++;
    if (wb_if.fwd_hit !== 1'b1 || wb_if.fwd_data !== 16'd64) begin
      bad++; $display("FAIL fwd_young got hit=%0b data=%0h exp 1/40", wb_if.fwd_hit, wb_if.fwd_data);
    end
    wb_if.fwd_addr = 5;
    #1;
    total++;
    if (wb_if.fwd_hit !== 1'b0 || wb_if.fwd_data !== 16'd0) begin
      bad++; $display("FAIL fwd_miss got hit=%0b data=%0h exp 0/0", wb_if.fwd_hit, wb_if.fwd_data);
    end
    wb_if.fwd_addr = 2;
    tick();
    total++;
    if (wb_if.fwd_hit !== 1'b1 || wb_if.fwd_data !== 16'd64) begin
      bad++; $display("FAIL fwd_issue got hit=%0b data=%0h exp 1/40", wb_if.fwd_hit, wb_if.fwd_data);
    end
    tick();
    total++;
    if (wb_if.fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_committed got=%0b exp=0", wb_if.fwd_hit); end
  endtask

  task automatic test_idle_hold;
    wb_if.alu_valid = 1; wb_if.alu_rd = 3; wb_if.alu_data = 16'h55;
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wb_if.sig_enable_write1 !== 1'b0 || wb_if.sig_enable_write2 !== 1'b0 ||
          wb_if.RW !== 3'd3 || wb_if.BusW1 !== 16'h55) begin
        bad++; $display("FAIL idle_hold[%0d] got RW=%0d W1=%0h en=%0b%0b exp 3/55/00", i, wb_if.RW, wb_if.BusW1,
                        wb_if.sig_enable_write1, wb_if.sig_enable_write2);
      end
    end
  endtask

  task automatic test_reset_mid;
    wb_if.mem_valid = 1; wb_if.mem_rd = 4; wb_if.mem_data = 16'h1111;
    wb_if.alu_valid = 1; wb_if.alu_rd = 5; wb_if.alu_data = 16'h2222;
    tick();
    wb_if.mem_rd = 6; wb_if.mem_data = 16'h3333;
    wb_if.alu_rd = 7; wb_if.alu_data = 16'h4444;
    tick();
    idle_in();
    total++;
    if (pending_count !== 2'd2 || wb_if.sig_enable_write1 !== 1'b1) begin
      bad++; $display("FAIL rmid_setup got cnt=%0d en1=%0b exp 2/1", pending_count, wb_if.sig_enable_write1);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (wb_if.sig_enable_write1 !== 1'b0 || wb_if.sig_enable_write2 !== 1'b0 || pending_count !== 2'd0 ||
        wb_if.RW !== 3'd0 || wb_if.BusW1 !== 16'd0) begin
      bad++; $display("FAIL rmid_async got en=%0b%0b cnt=%0d RW=%0d W1=%0h exp 00/0/0/0", wb_if.sig_enable_write1,
                      wb_if.sig_enable_write2, pending_count, wb_if.RW, wb_if.BusW1);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total += 2;
    if (wb_if.sig_enable_write1 !== 1'b0 || wb_if.sig_enable_write2 !== 1'b0) begin
      bad++; $display("FAIL rmid_quiet got en=%0b%0b exp=00", wb_if.sig_enable_write1, wb_if.sig_enable_write2);
    end
    if (rf[4] !== 16'h1111 || rf[5] !== 16'h200 || rf[6] !== 16'h101 || rf[7] !== 16'h201) begin
      bad++; $display("FAIL rmid_rf got r4=%0h r5=%0h r6=%0h r7=%0h exp 1111/200/101/201", rf[4], rf[5], rf[6], rf[7]);
    end
    wb_if.alu_valid = 1; wb_if.alu_rd = 6; wb_if.alu_data = 16'h77;
    tick();
    idle_in();
    total++;
    if (wb_if.sig_enable_write1 !== 1'b1 || wb_if.RW !== 3'd6 || wb_if.BusW1 !== 16'h77) begin
      bad++; $display("FAIL rmid_after got en1=%0b RW=%0d W1=%0h exp 1/6/77", wb_if.sig_enable_write1, wb_if.RW, wb_if.BusW1);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_fill();
    test_forward();
    test_idle_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
